// File: rtl/sqrt_ctrl_seq.sv
// Control sequencer for the iterative square-root datapath.
// IDLE -> LOAD (operand write pulse) -> RUN (iterate until N flag or limit)
// -> optional DRAIN (pipeline flush) -> DONE (result held until accepted).
module sqrt_ctrl_seq #(
    parameter int MAX_ITER     = 16,
    parameter int DRAIN_CYC    = 0,
    parameter bit STOP_ON_FLAG = 1'b1,
    parameter int CNT_W        = $clog2(MAX_ITER + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             N_i,
    input  logic             out_ready_i,
    output logic             in_ready_o,
    output logic             wr_input_o,
    output logic             en_pipe_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] iter_cnt_o
);

    // Drain counter needs at least one bit even when draining is disabled.
    localparam int DW = (DRAIN_CYC > 0) ? $clog2(DRAIN_CYC + 1) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t         state, nxt;
    logic [CNT_W-1:0] cnt;
    logic [DW-1:0]    dcnt;
    logic             flag_stop, lim_stop, stop, drain_last;

    // A simultaneous flag and limit counts as a flag stop (no timeout).
    assign flag_stop  = STOP_ON_FLAG && N_i;
    assign lim_stop   = (cnt == CNT_W'(MAX_ITER - 1));
    assign stop       = flag_stop || lim_stop;
    assign drain_last = (dcnt == DW'(DRAIN_CYC - 1));

    // State register; reset dominates abort and all other inputs.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    // Next-state decode; abort wins over start everywhere, illegal codes recover to IDLE.
    always_comb begin
        nxt = IDLE;
        case (state)
            IDLE:  nxt = (start_i && !abort_i) ? LOAD : IDLE;
            LOAD:  nxt = abort_i ? IDLE : RUN;
            RUN: begin
                if (abort_i)        nxt = IDLE;
                else if (!stop)     nxt = RUN;
                else if (DRAIN_CYC > 0) nxt = DRAIN;
                else                nxt = DONE;
            end
            DRAIN: nxt = abort_i ? IDLE : (drain_last ? DONE : DRAIN);
            DONE: begin
                if (abort_i)          nxt = IDLE;
                else if (!out_ready_i) nxt = DONE;
                else                  nxt = start_i ? LOAD : IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // Outputs decoded from state; unreachable encodings drive everything low.
    always_comb begin
        in_ready_o = 1'b0;
        wr_input_o = 1'b0;
        en_pipe_o  = 1'b0;
        valid_o    = 1'b0;
        busy_o     = 1'b0;
        case (state)
            IDLE:  in_ready_o = 1'b1;
            LOAD:  begin wr_input_o = 1'b1; busy_o = 1'b1; end
            RUN:   begin en_pipe_o  = 1'b1; busy_o = 1'b1; end
            DRAIN: begin en_pipe_o  = 1'b1; busy_o = 1'b1; end
            DONE:  begin valid_o    = 1'b1; in_ready_o = out_ready_i; end
            default: ;
        endcase
    end

    // Iteration/drain counters and result registers; an abort freezes the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            dcnt       <= '0;
            iter_cnt_o <= '0;
            timeout_o  <= 1'b0;
        end else if (!abort_i) begin
            case (state)
                LOAD: begin
                    cnt       <= '0;
                    timeout_o <= 1'b0;
                end
                RUN: begin
                    if (stop) begin
                        iter_cnt_o <= cnt + CNT_W'(1);
                        timeout_o  <= STOP_ON_FLAG && !N_i;
                        dcnt       <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DRAIN: dcnt <= dcnt + DW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_ctrl_seq.sv
// Directed bench for sqrt_ctrl_seq. Three instances share the stimulus:
//   0: MAX_ITER=16 D=0 flag stop, 1: D=3 flag stop, 2: D=0 flag ignored.
// Each scenario starts from reset and checks only the instance it targets.
module tb_sqrt_ctrl_seq;

    logic clk = 1'b0;
    logic rst, start_i, abort_i, N_i, out_ready_i;
    logic [2:0] in_ready, wr, en, valid, busy, tmo;
    logic [4:0] iter [3];
    int n_chk = 0, n_pass = 0;
    int en_cnt, vcyc;

    always #5 clk = ~clk;

    sqrt_ctrl_seq #(.MAX_ITER(16), .DRAIN_CYC(0), .STOP_ON_FLAG(1'b1)) u_a (
        .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i), .N_i(N_i),
        .out_ready_i(out_ready_i), .in_ready_o(in_ready[0]), .wr_input_o(wr[0]),
        .en_pipe_o(en[0]), .valid_o(valid[0]), .busy_o(busy[0]),
        .timeout_o(tmo[0]), .iter_cnt_o(iter[0]));

    sqrt_ctrl_seq #(.MAX_ITER(16), .DRAIN_CYC(3), .STOP_ON_FLAG(1'b1)) u_b (
        .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i), .N_i(N_i),
        .out_ready_i(out_ready_i), .in_ready_o(in_ready[1]), .wr_input_o(wr[1]),
        .en_pipe_o(en[1]), .valid_o(valid[1]), .busy_o(busy[1]),
        .timeout_o(tmo[1]), .iter_cnt_o(iter[1]));

    sqrt_ctrl_seq #(.MAX_ITER(16), .DRAIN_CYC(0), .STOP_ON_FLAG(1'b0)) u_c (
        .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i), .N_i(N_i),
        .out_ready_i(out_ready_i), .in_ready_o(in_ready[2]), .wr_input_o(wr[2]),
        .en_pipe_o(en[2]), .valid_o(valid[2]), .busy_o(busy[2]),
        .timeout_o(tmo[2]), .iter_cnt_o(iter[2]));

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; N_i = 1'b0; out_ready_i = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    // Launch one operation; N_i pulses during RUN cycle n_at (0 = never).
    // Returns en_pipe cycle count and the cycle in which valid_o first rises
    // (start accepted at edge 0 => LOAD is cycle 1).
    task automatic op(input int sel, input int n_at, output int ecnt, output int vc);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("wr_pulse", int'(wr[sel]), 1);
        ecnt = 0; vc = 0;
        for (int c = 1; c <= 60; c++) begin
            if (en[sel]) ecnt++;
            if (valid[sel]) begin vc = c; break; end
            N_i = (n_at != 0) && (c == n_at + 1);
            tick();
        end
        N_i = 1'b0;
        if (vc == 0) chk("valid_wait", 0, 1);
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_in_ready", int'(in_ready[0]), 1);
        chk("rst_wr", int'(wr[0]), 0);
        chk("rst_en", int'(en[0]), 0);
        chk("rst_valid", int'(valid[0]), 0);
        chk("rst_busy", int'(busy[0]), 0);
        chk("rst_iter", int'(iter[0]), 0);
        chk("rst_tmo", int'(tmo[0]), 0);

        // Flag stop in 5th RUN cycle
        op(0, 5, en_cnt, vcyc);
        chk("t2_en", en_cnt, 5);
        chk("t2_vcyc", vcyc, 7);
        chk("t2_iter", int'(iter[0]), 5);
        chk("t2_tmo", int'(tmo[0]), 0);
        chk("t2_busy", int'(busy[0]), 0);
        chk("t2_in_ready_lo", int'(in_ready[0]), 0);
        // Hold for 4 cycles with consumer stalled
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t5_valid_hold", int'(valid[0]), 1);
            chk("t5_iter_hold", int'(iter[0]), 5);
        end
        // Back-to-back: accept result and new start in one cycle
        out_ready_i = 1'b1; start_i = 1'b1;
        #1;
        chk("t5_in_ready", int'(in_ready[0]), 1);
        tick();
        start_i = 1'b0; out_ready_i = 1'b0;
        chk("t5_wr", int'(wr[0]), 1);
        chk("t5_valid_drop", int'(valid[0]), 0);
        tick();
        chk("t5_wr_once", int'(wr[0]), 0);
        chk("t5_run_en", int'(en[0]), 1);
        // Reset held 2 cycles mid-RUN (previous result iter=5 must clear)
        tick();
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        chk("t1_in_ready", int'(in_ready[0]), 1);
        chk("t1_en", int'(en[0]), 0);
        chk("t1_busy", int'(busy[0]), 0);
        chk("t1_valid", int'(valid[0]), 0);
        chk("t1_iter", int'(iter[0]), 0);
        chk("t1_tmo", int'(tmo[0]), 0);

        // Iteration limit with N_i held low
        do_reset();
        op(0, 0, en_cnt, vcyc);
        chk("t3_en", en_cnt, 16);
        chk("t3_vcyc", vcyc, 18);
        chk("t3_iter", int'(iter[0]), 16);
        chk("t3_tmo", int'(tmo[0]), 1);
        // Accept without restart -> IDLE
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        chk("t3_idle_valid", int'(valid[0]), 0);
        chk("t3_idle_ready", int'(in_ready[0]), 1);
        chk("t3_tmo_held", int'(tmo[0]), 1);

        // Flag and limit in the same cycle: flag wins, no timeout
        do_reset();
        op(0, 16, en_cnt, vcyc);
        chk("lim_flag_iter", int'(iter[0]), 16);
        chk("lim_flag_tmo", int'(tmo[0]), 0);

        // Flag ignored when STOP_ON_FLAG=0
        do_reset();
        op(2, 3, en_cnt, vcyc);
        chk("t3b_en", en_cnt, 16);
        chk("t3b_iter", int'(iter[2]), 16);
        chk("t3b_tmo", int'(tmo[2]), 0);

        // Drain of 3 cycles after a 2-cycle RUN
        do_reset();
        op(1, 2, en_cnt, vcyc);
        chk("t4_en", en_cnt, 5);
        chk("t4_vcyc", vcyc, 7);
        chk("t4_iter", int'(iter[1]), 2);
        chk("t4_tmo", int'(tmo[1]), 0);

        // Abort in 3rd RUN cycle
        do_reset();
        start_i = 1'b1; tick(); start_i = 1'b0;
        tick(); tick(); tick();
        chk("t6_in_run", int'(en[0]), 1);
        abort_i = 1'b1; tick(); abort_i = 1'b0;
        chk("t6_idle_ready", int'(in_ready[0]), 1);
        chk("t6_busy", int'(busy[0]), 0);
        chk("t6_en", int'(en[0]), 0);
        for (int k = 0; k < 20; k++) begin
            tick();
            if (valid[0]) chk("t6_no_valid", int'(valid[0]), 0);
        end
        chk("t6_iter_kept", int'(iter[0]), 0);
        // Abort in IDLE blocks a same-cycle start
        abort_i = 1'b1; start_i = 1'b1; tick();
        abort_i = 1'b0; start_i = 1'b0;
        chk("idle_abort_wr", int'(wr[0]), 0);
        chk("idle_abort_busy", int'(busy[0]), 0);
        // Fresh operation after abort
        op(0, 4, en_cnt, vcyc);
        chk("t6_fresh_en", en_cnt, 4);
        chk("t6_fresh_vcyc", vcyc, 6);
        chk("t6_fresh_iter", int'(iter[0]), 4);
        // Abort in DONE discards result but keeps iter
        abort_i = 1'b1; tick(); abort_i = 1'b0;
        chk("done_abort_valid", int'(valid[0]), 0);
        chk("done_abort_iter", int'(iter[0]), 4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
